// File: rtl/opti_coef_loader_if.sv
// Coefficient write / commit handshake between a host and opti_coef_loader.
interface opti_coef_loader_if;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [23:0] wr_data;
  logic        wr_ready;
  logic        wr_err;
  logic        commit;
  logic        commit_busy;
  logic        commit_done;

  modport master (
    output wr_en, wr_addr, wr_data, commit,
    input  wr_ready, wr_err, commit_busy, commit_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit,
    output wr_ready, wr_err, commit_busy, commit_done
  );
endinterface

// File: rtl/opti_coef_loader.sv
// Double-buffered SOS coefficient loader: host writes a shadow bank, which is
// swapped into the active bank as a whole once the sample stream goes quiet.
module opti_coef_loader #(
  parameter int unsigned NUM_SECT  = 4,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  opti_coef_loader_if.slave      cfg,
  input  logic                   sample_valid,
  output logic [NUM_SECT*24-1:0] b0_o,
  output logic [NUM_SECT*24-1:0] b1_o,
  output logic [NUM_SECT*24-1:0] b2_o,
  output logic [NUM_SECT*24-1:0] a1_o,
  output logic [NUM_SECT*24-1:0] a2_o,
  output logic                   bank_id
);

  localparam int unsigned CW    = 24;
  localparam int unsigned NCOEF = 5;
  localparam int unsigned QW    = $clog2(DRAIN_CYC + 1);
  localparam logic [CW-1:0] UNITY = 24'h400000;

  typedef enum logic [1:0] {IDLE, PENDING, SWAP} state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q;
  logic          wr_ready_q, wr_err_q, busy_q, done_q, bank_q;

  logic [CW-1:0] shadow_q [NUM_SECT][NCOEF];
  logic [CW-1:0] active_q [NUM_SECT][NCOEF];

  logic [1:0] wr_sec;
  logic [2:0] wr_idx;
  logic       addr_ok, wr_accept, commit_accept, quiet;

  assign wr_sec        = cfg.wr_addr[4:3];
  assign wr_idx        = cfg.wr_addr[2:0];
  assign addr_ok       = (wr_idx < 3'd5) && (32'(wr_sec) < NUM_SECT);
  assign wr_accept     = cfg.wr_en && addr_ok && wr_ready_q;
  assign commit_accept = cfg.commit && wr_ready_q;
  assign quiet         = (qcnt_q == QW'(DRAIN_CYC)) && !sample_valid;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit_accept) state_d = PENDING;
      PENDING: if (quiet)         state_d = SWAP;
      SWAP:                       state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Quiet counter and registered status; the commit cycle itself counts as the
  // first quiet cycle so the drain window always starts fresh at commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qcnt_q     <= '0;
      wr_ready_q <= 1'b0;
      wr_err_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bank_q     <= 1'b0;
    end else begin
      if (sample_valid)                     qcnt_q <= '0;
      else if (commit_accept)               qcnt_q <= QW'(1);
      else if (qcnt_q != QW'(DRAIN_CYC))    qcnt_q <= qcnt_q + QW'(1);
      wr_ready_q <= (state_d == IDLE);
      wr_err_q   <= cfg.wr_en && !wr_accept;
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_q == SWAP);
      if (state_q == SWAP) bank_q <= ~bank_q;
    end
  end

  // Coefficient banks; active only ever changes as a whole on the swap edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SECT; s++) begin
        for (int k = 0; k < NCOEF; k++) begin
          shadow_q[s][k] <= (k == 0) ? UNITY : '0;
          active_q[s][k] <= (k == 0) ? UNITY : '0;
        end
      end
    end else begin
      if (wr_accept) shadow_q[wr_sec][wr_idx] <= cfg.wr_data;
      if (state_q == SWAP) begin
        for (int s = 0; s < NUM_SECT; s++) begin
          for (int k = 0; k < NCOEF; k++) active_q[s][k] <= shadow_q[s][k];
        end
      end
    end
  end

  assign cfg.wr_ready    = wr_ready_q;
  assign cfg.wr_err      = wr_err_q;
  assign cfg.commit_busy = busy_q;
  assign cfg.commit_done = done_q;
  assign bank_id         = bank_q;

  for (genvar s = 0; s < NUM_SECT; s++) begin : g_out
    assign b0_o[s*CW +: CW] = active_q[s][0];
    assign b1_o[s*CW +: CW] = active_q[s][1];
    assign b2_o[s*CW +: CW] = active_q[s][2];
    assign a1_o[s*CW +: CW] = active_q[s][3];
    assign a2_o[s*CW +: CW] = active_q[s][4];
  end

endmodule

// File: tb/tb_opti_coef_loader.sv
// Scoreboard bench for opti_coef_loader: commit snapshots of a shadow model are
// queued and compared against the active outputs when commit_done fires.
module tb_opti_coef_loader;

  localparam int NS = 4;
  localparam int DR = 4;
  localparam int BW = NS*24;
  localparam int VW = NS*5*24;

  logic clk, rst_n, sample_valid, bank_id;
  logic [BW-1:0] b0_o, b1_o, b2_o, a1_o, a2_o;

  opti_coef_loader_if cfg ();

  opti_coef_loader #(.NUM_SECT(NS), .DRAIN_CYC(DR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg          (cfg),
    .sample_valid (sample_valid),
    .b0_o         (b0_o),
    .b1_o         (b1_o),
    .b2_o         (b2_o),
    .a1_o         (a1_o),
    .a2_o         (a2_o),
    .bank_id      (bank_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [VW-1:0] sh_v, act_v;
  logic [VW-1:0] sb_q [$];
  bit m_pending, m_ready, m_bank, exact_lat;
  int cyc, commit_cyc;
  int checks, errors;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] pass_through();
    logic [VW-1:0] v;
    v = '0;
    for (int s = 0; s < NS; s++) v[(s*5)*24 +: 24] = 24'h400000;
    return v;
  endfunction

  function automatic logic [BW-1:0] exp_bus(input int k);
    logic [BW-1:0] r;
    for (int s = 0; s < NS; s++) r[s*24 +: 24] = act_v[(s*5+k)*24 +: 24];
    return r;
  endfunction

  // One clock of stimulus; model updated before the edge, DUT checked after it
  task automatic step(input logic we, input logic [4:0] addr, input logic [23:0] data,
                      input logic cm, input logic sv);
    logic err_e;
    int sec, idx;
    sec = int'(addr[4:3]);
    idx = int'(addr[2:0]);
    cfg.wr_en = we; cfg.wr_addr = addr; cfg.wr_data = data;
    cfg.commit = cm; sample_valid = sv;
    err_e = 1'b0;
    if (we) begin
      if (m_ready && !m_pending && idx < 5 && sec < NS) sh_v[(sec*5+idx)*24 +: 24] = data;
      else err_e = 1'b1;
    end
    if (cm && m_ready && !m_pending) begin
      m_pending = 1'b1;
      sb_q.push_back(sh_v);
      commit_cyc = cyc;
    end
    @(posedge clk); #1;
    cyc++;
    m_ready = 1'b1;
    cfg.wr_en = 1'b0; cfg.commit = 1'b0;
    if (cfg.commit_done === 1'b1 && sb_q.size() > 0) begin
      act_v = sb_q.pop_front();
      m_bank = ~m_bank;
      m_pending = 1'b0;
      if (exact_lat) chk("latency", 128'(cyc - commit_cyc), 128'(DR + 2));
    end else begin
      chk("done_idle", 128'(cfg.commit_done), 128'(0));
    end
    chk("wr_err",   128'(cfg.wr_err),      128'(err_e));
    chk("wr_ready", 128'(cfg.wr_ready),    128'(!m_pending));
    chk("busy",     128'(cfg.commit_busy), 128'(m_pending));
    chk("bank_id",  128'(bank_id),         128'(m_bank));
    chk("b0_o", 128'(b0_o), 128'(exp_bus(0)));
    chk("b1_o", 128'(b1_o), 128'(exp_bus(1)));
    chk("b2_o", 128'(b2_o), 128'(exp_bus(2)));
    chk("a1_o", 128'(a1_o), 128'(exp_bus(3)));
    chk("a2_o", 128'(a2_o), 128'(exp_bus(4)));
  endtask

  task automatic idle(input logic sv);
    step(1'b0, 5'd0, 24'd0, 1'b0, sv);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && m_pending; i++) idle(1'b0);
    chk("done_timeout", 128'(m_pending), 128'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg.wr_en = 1'b0; cfg.commit = 1'b0; sample_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 128'(cfg.wr_ready),    128'(0));
    chk("rst_busy",  128'(cfg.commit_busy), 128'(0));
    chk("rst_done",  128'(cfg.commit_done), 128'(0));
    chk("rst_err",   128'(cfg.wr_err),      128'(0));
    chk("rst_bank",  128'(bank_id),         128'(0));
    chk("rst_b0",    128'(b0_o),            128'({NS{24'h400000}}));
    chk("rst_a2",    128'(a2_o),            128'(0));
    sh_v = pass_through(); act_v = pass_through();
    sb_q.delete();
    m_pending = 1'b0; m_ready = 1'b0; m_bank = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; commit_cyc = 0; exact_lat = 1'b0;
    cfg.wr_addr = '0; cfg.wr_data = '0;
    do_reset();
    idle(1'b0);
    idle(1'b0);

    // Single write then commit with a permanently quiet stream
    exact_lat = 1'b1;
    step(1'b1, {2'd1, 3'd1}, 24'hC00000, 1'b0, 1'b0);
    step(1'b0, 5'd0, 24'd0, 1'b1, 1'b0);
    wait_done(30);
    exact_lat = 1'b0;
    chk("b1_s1", 128'(b1_o[47:24]), 128'(24'hC00000));
    chk("bank1", 128'(bank_id), 128'(1));

    // Stream never quiet long enough: commit stays pending
    step(1'b1, {2'd2, 3'd0}, 24'h200000, 1'b0, 1'b0);
    step(1'b0, 5'd0, 24'd0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) idle(((i / 2) % 2) == 0);
    chk("busy_hold", 128'(cfg.commit_busy), 128'(1));
    wait_done(20);

    // Bad addresses and writes during pending are rejected
    step(1'b1, 5'b00101, 24'h7FFFFF, 1'b0, 1'b0);
    step(1'b1, 5'b11111, 24'h0F0F0F, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b0, 5'd0, 24'd0, 1'b1, 1'b0);
    step(1'b1, {2'd0, 3'd2}, 24'h0ABCDE, 1'b0, 1'b0);
    step(1'b1, {2'd3, 3'd3}, 24'h055555, 1'b1, 1'b0);
    wait_done(30);

    // Write and commit in the same cycle
    step(1'b1, {2'd3, 3'd4}, 24'h123456, 1'b1, 1'b0);
    wait_done(30);
    chk("a2_s3", 128'(a2_o[95:72]), 128'(24'h123456));

    // Reset in the middle of a pending commit discards everything
    step(1'b1, {2'd0, 3'd2}, 24'h111111, 1'b0, 1'b0);
    step(1'b0, 5'd0, 24'd0, 1'b1, 1'b1);
    repeat (3) idle(1'b1);
    chk("pend_busy", 128'(cfg.commit_busy), 128'(1));
    do_reset();
    for (int i = 0; i < 10; i++) idle(1'b0);
    chk("post_b2", 128'(b2_o), 128'(0));
    step(1'b0, 5'd0, 24'd0, 1'b1, 1'b0);
    wait_done(30);
    chk("post_b2_swap", 128'(b2_o[23:0]), 128'(0));
    chk("post_a2_swap", 128'(a2_o), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
